ddr3_avl_responder: RTL and testbench
=====================================

DDR3_AVL_RESPONDER -- requirements
Module: ddr3_avl_responder

Interface
REQ-001 Parameter MEM_ADDR_BITS, default 10: backing-store depth is 2^MEM_ADDR_BITS words of 128 bits.
REQ-002 Parameter READ_LATENCY, default 4: cycles from read acceptance to the first read beat; legal range 1..16.
REQ-003 Parameter REFRESH_INTERVAL, default 1024: period of the refresh stall in cycles; 0 disables refresh.
REQ-004 Parameter REFRESH_CYCLES, default 8: duration of the refresh stall with ready low.
REQ-005 ddr3_clk  in  1  sole clock.
REQ-006 ddr3_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 ddr3_avl_burstbegin  in  1  first beat of a command.
REQ-008 ddr3_avl_size  in  3  burst length; 0 means 8 beats.
REQ-009 ddr3_avl_read_req  in  1  read command.
REQ-010 ddr3_avl_write_req  in  1  write beat or command.
REQ-011 ddr3_avl_addr  in  26  word address; only the low MEM_ADDR_BITS bits are used.
REQ-012 ddr3_avl_wr_data  in  128  write beat data.
REQ-013 ddr3_avl_ready  out  1  registered; the responder accepts a request or beat on a cycle where req and ready are both high.
REQ-014 ddr3_avl_read_data_valid  out  1  read beat strobe.
REQ-015 ddr3_avl_read_data  out  128  read beat data.
REQ-016 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-017 States SHALL be IDLE, WR_BURST, RD_BURST and REFRESH, with ready high only in IDLE and WR_BURST.
REQ-018 In IDLE, read_req with ready SHALL latch addr and size (beats N = size, or 8 if size is 0) and enter RD_BURST at acceptance edge E0.
REQ-019 In RD_BURST, beat k (k = 0..N-1) SHALL be fetched from word (addr + k) mod 2^MEM_ADDR_BITS at edge E0+1+k.
REQ-020 Beat k SHALL appear with read_data_valid high in cycle E0+READ_LATENCY+k; beats are contiguous with no gaps.
REQ-021 Ready SHALL be low from E0 through edge E0+N, and the state SHALL return to IDLE (or REFRESH if a refresh is pending) at E0+N.
REQ-022 The read-data delay pipeline SHALL drain independently, so a new command may be accepted while earlier beats are still emerging.
REQ-023 In IDLE, write_req with burstbegin and ready SHALL write wr_data to word addr, latch addr and N, and enter WR_BURST; if N is 1, the state stays IDLE.
REQ-024 In WR_BURST, each cycle with write_req high SHALL write beat j to word (latched addr + j) mod 2^MEM_ADDR_BITS.
REQ-025 Cycles in WR_BURST with write_req low SHALL be idle gaps, with no write and no timeout.
REQ-026 After the N-th beat is written, the state SHALL go to IDLE, or to REFRESH if a refresh is pending.
REQ-027 Address arithmetic SHALL be MEM_ADDR_BITS wide and wrap modulo 2^MEM_ADDR_BITS.
REQ-028 A free-running refresh counter SHALL set refresh_pending every REFRESH_INTERVAL cycles.
REQ-029 A pending refresh SHALL be entered only from IDLE or at burst completion, never mid-burst.
REQ-030 A pending refresh SHALL take priority over a simultaneous new request in IDLE; that request is not accepted.
REQ-031 REFRESH SHALL hold ready low for exactly REFRESH_CYCLES cycles, then return to IDLE.
REQ-032 Counter expiry during REFRESH SHALL leave refresh_pending set for the next refresh.
REQ-033 read_req and write_req both high in IDLE SHALL serve the read, ignore the write and set proto_err.
REQ-034 burstbegin with write_req in WR_BURST SHALL set proto_err and restart the burst at the new addr and size, with that beat written.
REQ-035 read_req in WR_BURST SHALL set proto_err and be ignored.
REQ-036 proto_err SHALL clear only on reset.

Reset
REQ-037 While ddr3_reset_n is low: state IDLE, ready 0, read_data_valid 0, read_data 0, proto_err 0, refresh counter 0, refresh_pending 0, and the delay pipeline cleared immediately.
REQ-038 Ready SHALL rise on the first ddr3_clk edge after reset release.
REQ-039 A reset mid-burst SHALL abandon the burst; no further beats are produced or written.
REQ-040 Memory contents SHALL NOT be reset; reads of unwritten words return undefined data.

Verification
REQ-041 Write: burst size 4 to addr 0x010, data 0xA..0xD. Then read size 4 at addr 0x010, accepted at E0. Required: ready low E0..E0+4, and valid high in cycles E0+4..E0+7 with data 0xA,0xB,0xC,0xD.
REQ-042 Write: size 4 at addr 0x3FE, MEM_ADDR_BITS 10, with write_req gaps between beats. Required: single-word reads of 0x3FE, 0x3FF, 0x000 and 0x001 return the four beats in order.
REQ-043 Refresh: REFRESH_INTERVAL 64, REFRESH_CYCLES 8, idle bus. Required: ready low for exactly 8 cycles every 64. Counter expiry during a size-0 (8-beat) read delays the stall until the last fetch.
REQ-044 Simultaneous: read_req and write_req both high in IDLE. Required: read served, memory unchanged, proto_err 1 until reset.
REQ-045 Back-to-back: two size-4 reads with READ_LATENCY 4. Required: 8 valid beats with a 1-cycle gap between bursts (second accept at E0+5).
REQ-046 Reset: assert reset at the 2nd beat of a read burst. Required: valid 0 immediately. After release: ready 1 at the first edge, and no stale beats appear.

Source files
------------

// File: rtl/ddr3_avl_responder.sv
// Behavioural DDR3 Avalon-MM responder: a 128-bit backing store with fixed read latency,
// periodic refresh stalls and a sticky protocol-error flag.
module ddr3_avl_responder #(
    parameter int MEM_ADDR_BITS    = 10,
    parameter int READ_LATENCY     = 4,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic         ddr3_clk,
    input  logic         ddr3_reset_n,
    input  logic         ddr3_avl_burstbegin,
    input  logic [2:0]   ddr3_avl_size,
    input  logic         ddr3_avl_read_req,
    input  logic         ddr3_avl_write_req,
    input  logic [25:0]  ddr3_avl_addr,
    input  logic [127:0] ddr3_avl_wr_data,
    output logic         ddr3_avl_ready,
    output logic         ddr3_avl_read_data_valid,
    output logic [127:0] ddr3_avl_read_data,
    output logic         proto_err
);
    localparam int AW    = MEM_ADDR_BITS;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {ST_IDLE, ST_WR_BURST, ST_RD_BURST, ST_REFRESH} state_t;

    state_t         r_state;
    logic           r_ready;
    logic [AW-1:0]  r_addr;
    logic [3:0]     r_beats;
    logic [3:0]     r_beat;
    logic           r_refresh_pending;
    logic [31:0]    r_refresh_cnt;
    logic [15:0]    r_stall_cnt;
    logic           r_proto_err;
    logic [127:0]   r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [127:0]   r_pipe_dat [READ_LATENCY];

    state_t         w_state_nxt;
    state_t         w_done_state;
    logic [AW-1:0]  w_req_addr;
    logic [AW-1:0]  w_burst_addr;
    logic [AW-1:0]  w_waddr;
    logic [3:0]     w_req_beats;
    logic [3:0]     w_beat_nxt;
    logic           w_we;
    logic           w_latch;
    logic           w_fetch;
    logic           w_err_set;
    logic           w_expire;
    logic           w_pend;
    logic           w_rd_acc;
    logic           w_wr_acc;
    logic           w_addr_unused;

    assign w_req_addr    = ddr3_avl_addr[AW-1:0];
    assign w_addr_unused = &{1'b0, ddr3_avl_addr[25:AW]};
    assign w_req_beats   = (ddr3_avl_size == 3'd0) ? 4'd8 : {1'b0, ddr3_avl_size};
    assign w_burst_addr  = r_addr + AW'(r_beat);
    assign w_rd_acc      = ddr3_avl_read_req & r_ready;
    assign w_wr_acc      = ddr3_avl_write_req & r_ready;
    // An expiry on this very edge counts as pending so an idle bus stalls without a lost cycle.
    assign w_pend        = r_refresh_pending | w_expire;

    generate
        if (REFRESH_INTERVAL == 0) begin : g_no_refresh
            assign w_expire = 1'b0;
        end else begin : g_refresh
            assign w_expire = (r_refresh_cnt == 32'(REFRESH_INTERVAL - 1));
        end
    endgenerate

    // Next-state, write-port and fetch decode
    always_comb begin
        w_state_nxt  = r_state;
        w_done_state = w_pend ? ST_REFRESH : ST_IDLE;
        w_we         = 1'b0;
        w_waddr      = w_req_addr;
        w_latch      = 1'b0;
        w_fetch      = 1'b0;
        w_beat_nxt   = r_beat;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend) begin
                    w_state_nxt = ST_REFRESH;
                end else if (w_rd_acc) begin
                    w_latch     = 1'b1;
                    w_beat_nxt  = 4'd0;
                    w_state_nxt = ST_RD_BURST;
                    w_err_set   = ddr3_avl_write_req;
                end else if (w_wr_acc && ddr3_avl_burstbegin) begin
                    w_we        = 1'b1;
                    w_latch     = 1'b1;
                    w_beat_nxt  = 4'd1;
                    w_state_nxt = (w_req_beats == 4'd1) ? ST_IDLE : ST_WR_BURST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_BURST: begin
                w_err_set = ddr3_avl_read_req;
                if (w_wr_acc && ddr3_avl_burstbegin) begin
                    w_err_set   = 1'b1;
                    w_we        = 1'b1;
                    w_latch     = 1'b1;
                    w_beat_nxt  = 4'd1;
                    w_state_nxt = (w_req_beats == 4'd1) ? w_done_state : ST_WR_BURST;
                end else if (w_wr_acc) begin
                    w_we        = 1'b1;
                    w_waddr     = w_burst_addr;
                    w_beat_nxt  = r_beat + 4'd1;
                    w_state_nxt = (r_beat == r_beats - 4'd1) ? w_done_state : ST_WR_BURST;
                end else begin
                    w_state_nxt = ST_WR_BURST;
                end
            end
            ST_RD_BURST: begin
                w_fetch     = 1'b1;
                w_beat_nxt  = r_beat + 4'd1;
                w_state_nxt = (r_beat == r_beats - 4'd1) ? w_done_state : ST_RD_BURST;
            end
            ST_REFRESH: begin
                if (r_stall_cnt == 16'(REFRESH_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REFRESH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state, burst context, refresh bookkeeping and the sticky error flag
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_state           <= ST_IDLE;
            r_ready           <= 1'b0;
            r_addr            <= '0;
            r_beats           <= 4'd0;
            r_beat            <= 4'd0;
            r_refresh_pending <= 1'b0;
            r_refresh_cnt     <= 32'd0;
            r_stall_cnt       <= 16'd0;
            r_proto_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_WR_BURST);
            r_beat      <= w_beat_nxt;
            r_stall_cnt <= (r_state == ST_REFRESH) ? r_stall_cnt + 16'd1 : 16'd0;
            r_refresh_cnt <= w_expire ? 32'd0 : r_refresh_cnt + 32'd1;
            if (w_latch) begin
                r_addr  <= w_req_addr;
                r_beats <= w_req_beats;
            end
            if ((w_state_nxt == ST_REFRESH) && (r_state != ST_REFRESH)) begin
                r_refresh_pending <= 1'b0;
            end else if (w_expire) begin
                r_refresh_pending <= 1'b1;
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Backing store write port; contents deliberately survive reset
    always_ff @(posedge ddr3_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= ddr3_avl_wr_data;
        end
    end

    // Fetch plus read-latency delay line, draining independently of the control state
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_dat[i] <= 128'd0;
            end
        end else begin
            r_pipe_vld[0] <= w_fetch;
            if (w_fetch) begin
                r_pipe_dat[0] <= r_mem[w_burst_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    assign ddr3_avl_ready           = r_ready;
    assign ddr3_avl_read_data_valid = r_pipe_vld[READ_LATENCY-1];
    assign ddr3_avl_read_data       = r_pipe_dat[READ_LATENCY-1];
    assign proto_err                = r_proto_err;
endmodule

// File: tb/tb_ddr3_avl_responder.sv
// Scoreboard bench for ddr3_avl_responder: one instance with refresh off for data paths,
// one with a 64-cycle refresh for stall timing.
module tb_ddr3_avl_responder;
    logic         clk = 1'b0;
    logic         rst_n, rst2_n;
    logic         bb, rd, wr;
    logic [2:0]   size;
    logic [25:0]  addr;
    logic [127:0] wdata;
    logic         ready, vld, perr;
    logic [127:0] rdata;
    logic         rd2, zero2;
    logic [25:0]  addr2;
    logic [127:0] wdata2;
    logic         ready2, vld2, perr2;
    logic [127:0] rdata2;

    typedef struct { logic [127:0] data; int cyc; } exp_t;
    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [127:0] model_mem [1024];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr3_avl_responder #(.MEM_ADDR_BITS(10), .READ_LATENCY(4), .REFRESH_INTERVAL(0),
                         .REFRESH_CYCLES(8)) u_dut (
        .ddr3_clk(clk), .ddr3_reset_n(rst_n), .ddr3_avl_burstbegin(bb),
        .ddr3_avl_size(size), .ddr3_avl_read_req(rd), .ddr3_avl_write_req(wr),
        .ddr3_avl_addr(addr), .ddr3_avl_wr_data(wdata), .ddr3_avl_ready(ready),
        .ddr3_avl_read_data_valid(vld), .ddr3_avl_read_data(rdata), .proto_err(perr));

    ddr3_avl_responder #(.MEM_ADDR_BITS(10), .READ_LATENCY(4), .REFRESH_INTERVAL(64),
                         .REFRESH_CYCLES(8)) u_dut_ref (
        .ddr3_clk(clk), .ddr3_reset_n(rst2_n), .ddr3_avl_burstbegin(zero2),
        .ddr3_avl_size(3'd0), .ddr3_avl_read_req(rd2), .ddr3_avl_write_req(zero2),
        .ddr3_avl_addr(addr2), .ddr3_avl_wr_data(wdata2), .ddr3_avl_ready(ready2),
        .ddr3_avl_read_data_valid(vld2), .ddr3_avl_read_data(rdata2), .proto_err(perr2));

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every read beat must match the oldest scoreboard entry in both data and cycle.
    always @(negedge clk) begin
        if (vld) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_beat", 128'd1, 128'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("rd_data", rdata, mon_e.data);
                check_eq("rd_cycle", 128'(cyc), 128'(mon_e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) check_eq("ready_timeout", 128'd0, 128'd1);
    endtask

    task automatic push_beats(input logic [9:0] a, input logic [2:0] s, input int e0);
        int n;
        logic [9:0] ix;
        n = (s == 3'd0) ? 8 : int'(s);
        for (int k = 0; k < n; k++) begin
            ix = a + 10'(k);
            sb_q.push_back('{data: model_mem[ix], cyc: e0 + 4 + k});
        end
    endtask

    task automatic rd_cmd(input logic [9:0] a, input logic [2:0] s, output int e0);
        wait_ready();
        addr = {16'd0, a};
        size = s;
        rd   = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        e0 = cyc;
        push_beats(a, s, e0);
    endtask

    task automatic wr_burst(input logic [9:0] a, input logic [2:0] s, input logic [127:0] base,
                            input bit gap);
        int n;
        logic [9:0] ix;
        n = (s == 3'd0) ? 8 : int'(s);
        wait_ready();
        addr  = {16'd0, a};
        size  = s;
        bb    = 1'b1;
        wr    = 1'b1;
        wdata = base;
        @(posedge clk); #1;
        model_mem[a] = base;
        bb = 1'b0;
        for (int j = 1; j < n; j++) begin
            if (gap) begin
                wr = 1'b0;
                @(posedge clk); #1;
            end
            wr    = 1'b1;
            wdata = base + 128'(j);
            @(posedge clk); #1;
            ix = a + 10'(j);
            model_mem[ix] = base + 128'(j);
        end
        wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1;
        int t;
        logic exp_rdy, exp_vld;
        rst_n = 1'b0; rst2_n = 1'b0;
        bb = 1'b0; rd = 1'b0; wr = 1'b0; size = 3'd0; addr = 26'd0; wdata = 128'd0;
        rd2 = 1'b0; zero2 = 1'b0; addr2 = 26'd0; wdata2 = 128'd0;

        // Reset values and first-edge ready
        repeat (3) @(negedge clk);
        check_eq("rst_ready", ready, 1'b0);
        check_eq("rst_valid", vld, 1'b0);
        check_eq("rst_data", rdata, 128'd0);
        check_eq("rst_proto_err", perr, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_release", ready, 1'b1);

        // Burst write then burst read with ready-low window
        wr_burst(10'h010, 3'd4, 128'hA, 1'b0);
        rd_cmd(10'h010, 3'd4, e0);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            check_eq("rd_ready_window", ready, (i == 4) ? 1'b1 : 1'b0);
        end

        // Wrapping write with gaps, read back one word at a time
        wr_burst(10'h3FE, 3'd4, 128'h1111, 1'b1);
        rd_cmd(10'h3FE, 3'd1, e0);
        rd_cmd(10'h3FF, 3'd1, e0);
        rd_cmd(10'h000, 3'd1, e0);
        rd_cmd(10'h001, 3'd1, e0);

        // Back-to-back 4-beat reads
        rd_cmd(10'h010, 3'd4, e0);
        rd_cmd(10'h3FE, 3'd4, e1);
        check_eq("b2b_accept", 128'(e1), 128'(e0 + 5));

        // 8-beat burst
        wr_burst(10'h100, 3'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        rd_cmd(10'h100, 3'd0, e0);
        check_eq("proto_err_clean", perr, 1'b0);

        // Simultaneous read and write in IDLE
        wait_ready();
        addr = 26'h010; size = 3'd1; rd = 1'b1; wr = 1'b1; bb = 1'b1; wdata = 128'hDEAD;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; bb = 1'b0;
        e0 = cyc;
        push_beats(10'h010, 3'd1, e0);
        @(negedge clk);
        check_eq("proto_err_simul", perr, 1'b1);
        rd_cmd(10'h010, 3'd1, e0);

        // Burst restart by a second burstbegin mid-burst
        wr_burst(10'h022, 3'd2, 128'h77, 1'b0);
        wait_ready();
        addr = 26'h020; size = 3'd4; bb = 1'b1; wr = 1'b1; wdata = 128'h20;
        @(posedge clk); #1;
        bb = 1'b0; wdata = 128'h21;
        @(posedge clk); #1;
        addr = 26'h030; size = 3'd2; bb = 1'b1; wdata = 128'h30;
        @(posedge clk); #1;
        bb = 1'b0; wdata = 128'h31;
        @(posedge clk); #1;
        wr = 1'b0;
        model_mem[10'h020] = 128'h20; model_mem[10'h021] = 128'h21;
        model_mem[10'h030] = 128'h30; model_mem[10'h031] = 128'h31;
        rd_cmd(10'h020, 3'd4, e0);
        rd_cmd(10'h030, 3'd2, e0);
        check_eq("proto_err_sticky", perr, 1'b1);

        // Reset on the second beat of a read burst
        rd_cmd(10'h010, 3'd4, e0);
        while (cyc < e0 + 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midburst_rst_valid", vld, 1'b0);
        check_eq("midburst_rst_data", rdata, 128'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_rerelease", ready, 1'b1);
        check_eq("proto_err_cleared", perr, 1'b0);
        repeat (12) @(negedge clk);

        // Read request inside a write burst is ignored and flagged
        wait_ready();
        addr = 26'h040; size = 3'd2; bb = 1'b1; wr = 1'b1; wdata = 128'h40;
        @(posedge clk); #1;
        bb = 1'b0; wr = 1'b0; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b1; wdata = 128'h41;
        @(posedge clk); #1;
        wr = 1'b0;
        model_mem[10'h040] = 128'h40; model_mem[10'h041] = 128'h41;
        @(negedge clk);
        check_eq("proto_err_rd_in_wr", perr, 1'b1);
        rd_cmd(10'h040, 3'd2, e0);

        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("sb_drain", 128'(sb_q.size()), 128'd0);

        // Refresh timing: idle stalls every 64 cycles, then one deferred by an 8-beat read
        @(negedge clk);
        rst2_n = 1'b1;
        for (int r = 1; r <= 206; r++) begin
            @(negedge clk);
            if (r >= 188 && r <= 203) exp_rdy = 1'b0;
            else if (r >= 64 && (r % 64) < 8) exp_rdy = 1'b0;
            else exp_rdy = 1'b1;
            exp_vld = (r >= 192 && r <= 199);
            check_eq("refresh_ready", ready2, exp_rdy);
            check_eq("refresh_rd_valid", vld2, exp_vld);
            if (r == 187) begin
                rd2   = 1'b1;
                addr2 = 26'h123;
            end else begin
                rd2 = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
